fifo_ctrl: RTL
==============

# fifo_ctrl

Pointer and flag controller for the synchronous FIFO. It sequences the flop-array FIFO memory (registered read, one-cycle read latency) by generating write/read addresses and enables from push/pop requests. It tracks occupancy and produces full/empty, almost-full/almost-empty and a read-data-valid strobe aligned to the memory's registered read data. It sits between the FIFO's client-facing push/pop interface and the memory array instance.

## Interface
- ADDR_WIDTH, 4, memory address width; must satisfy DEPTH <= 2**ADDR_WIDTH
- DEPTH, 16, number of entries, >= 2
- AFULL_THRESH, 14, almost_full asserted when count >= AFULL_THRESH
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  write request; the client presents write data to the memory in the same cycle
- pop  in  1  read request
- mem_write_addr  out  ADDR_WIDTH  write pointer, driven directly from register
- mem_read_addr  out  ADDR_WIDTH  read pointer, driven directly from register
- mem_write_enable  out  1  accepted push (combinational)
- mem_read_enable  out  1  accepted pop (combinational)
- rd_valid  out  1  memory read_data valid this cycle (registered)
- full, empty, almost_full, almost_empty  out  1 each  status flags (registered)
- count  out  ADDR_WIDTH+1  occupancy 0..DEPTH (registered)
- overflow, underflow  out  1 each  sticky error flags (see Configuration)

## Operation
- Accept rules:
  - wr_acc = push & (~full | pop)
  - rd_acc = pop & ~empty
  - mem_write_enable = wr_acc; mem_read_enable = rd_acc.
- Pointers wrap from DEPTH-1 to 0, not at 2**ADDR_WIDTH. A pointer increments on its accept.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither.
- Status is held as a 3-state occupancy FSM, EMPTY / PARTIAL / FULL:
  - EMPTY -> PARTIAL on wr_acc.
  - PARTIAL -> EMPTY when count==1 and rd_acc only.
  - PARTIAL -> FULL when count==DEPTH-1 and wr_acc only.
  - FULL -> PARTIAL on rd_acc only.
  - Simultaneous accepts hold the state.
- full = (state==FULL); empty = (state==EMPTY). Both are derived from next-state registers, so they are exact in the cycle after the update.
- almost_full and almost_empty are computed from next count and registered.
- Push while empty with pop: the push is accepted and the pop is rejected. There is no fall-through; data becomes readable the next cycle.
- Push while full with pop: both are accepted and count stays DEPTH. Write and read hit the same address; the memory returns the old entry (read-before-write), which is the correct FIFO order.
- Push while full without pop: dropped, with no pointer or count change.
- Pop while empty: ignored.

## Timing
- Reset values (applied on the first rising edge with rst=1):
  - pointers 0, count 0
  - state EMPTY: empty=1, full=0
  - almost_empty=1 (since 0 <= AEMPTY_THRESH), almost_full=0
  - rd_valid=0, overflow=0, underflow=0.
- Reset mid-operation discards all contents. The enables are forced to 0 while rst=1.
- Read latency: rd_acc at cycle N gives rd_valid=1 at N+1, aligned with the memory's read_data.
- Write is visible to a pop from the cycle after wr_acc.
- Flags and count reflect all accepts up to and including the previous edge. They are never combinational from push/pop.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- FIFO_CTRL_ERR_EN defined:
  - overflow sets sticky on push & full & ~pop.
  - underflow sets sticky on pop & empty.
  - Both clear only on rst.
- Undefined: overflow and underflow are tied to 0 and no error logic is synthesized. The accept/drop behaviour is identical in both builds.

## Test plan
- Reset, then 16 pushes (DEPTH=16) -> full=1 after the 16th edge, count=16, almost_full=1 from count 14, mem_write_addr back at 0.
- Full FIFO, push without pop -> mem_write_enable=0, count stays 16, overflow=1 (ERR_EN) or 0 (no ERR_EN).
- Full FIFO, push+pop for 20 cycles -> count stays 16, full stays 1, rd_valid every cycle, read data follows original write order across pointer wrap.
- Empty FIFO, push+pop same cycle -> count=1, empty=0, no rd_valid; pop the next cycle -> rd_valid one cycle later, empty=1.
- Pop on empty -> mem_read_enable=0, count=0, underflow=1 (ERR_EN).
- Assert rst with count=9 -> next cycle count=0, empty=1, pointers 0, rd_valid=0, error flags cleared.

Source files
------------

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer and flag controller for a synchronous FIFO built on a flop-array
// memory with registered read (one-cycle read latency). Turns client push/pop
// requests into memory write/read addresses and enables, tracks occupancy and
// produces registered status flags plus a read-data-valid strobe aligned with
// the memory's registered read data.
//
// Parameters:
//   ADDR_WIDTH     memory address width (DEPTH <= 2**ADDR_WIDTH)
//   DEPTH          number of entries (>= 2)
//   AFULL_THRESH   almost_full when count >= AFULL_THRESH
//   AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH
//
// Ports:
//   clk               in   clock, all state on rising edge
//   rst               in   synchronous active-high reset
//   push              in   write request (write data goes to memory same cycle)
//   pop               in   read request
//   mem_write_addr    out  write pointer (registered)
//   mem_read_addr     out  read pointer (registered)
//   mem_write_enable  out  accepted push (combinational)
//   mem_read_enable   out  accepted pop (combinational)
//   rd_valid          out  memory read data valid this cycle (registered)
//   full, empty       out  occupancy state flags (registered)
//   almost_full       out  registered threshold flag
//   almost_empty      out  registered threshold flag
//   count             out  occupancy 0..DEPTH (registered)
//   overflow          out  sticky push-while-full error
//   underflow         out  sticky pop-while-empty error
//
// Build option:
//   FIFO_CTRL_ERR_EN  when defined, overflow/underflow are sticky error flags
//                     cleared only by rst; otherwise both are tied to 0.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] C_PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   C_CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_AF_TH    = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   C_AE_TH    = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_vld_p1;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_only;
    logic                  w_rd_only;

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_state == ST_FULL);
    assign w_empty = (r_state == ST_EMPTY);

    // A push on a full FIFO is still accepted when a pop frees the slot in the
    // same cycle; the memory's read-before-write keeps FIFO order intact.
    // Both enables are suppressed while rst is high.
    assign w_wr_acc  = ~rst & push & (~w_full | pop);
    assign w_rd_acc  = ~rst & pop & ~w_empty;
    assign w_wr_only = w_wr_acc & ~w_rd_acc;
    assign w_rd_only = w_rd_acc & ~w_wr_acc;

    // ---- stage p0: accept decode, next occupancy ----
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;

        if (w_wr_only) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_rd_only) begin
            w_count_nxt = r_count - 1'b1;
        end

        case (r_state)
            ST_EMPTY: begin
                if (w_wr_acc) begin
                    w_state_nxt = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (w_rd_only && (r_count == C_CNT_ONE)) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_wr_only && (r_count == C_CNT_LAST)) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_rd_only) begin
                    w_state_nxt = ST_PARTIAL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- stage p1: registered pointers, count, flags, read-valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_vld_p1 <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_rd_acc) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count  <= w_count_nxt;
            r_afull  <= (w_count_nxt >= C_AF_TH);
            r_aempty <= (w_count_nxt <= C_AE_TH);
            // Memory read data is registered, so valid trails the accept by one cycle.
            r_vld_p1 <= w_rd_acc;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky until reset; a push on full with a simultaneous pop is legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push & w_full & ~pop) begin
                r_overflow <= 1'b1;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign mem_write_addr   = r_wptr;
    assign mem_read_addr    = r_rptr;
    assign mem_write_enable = w_wr_acc;
    assign mem_read_enable  = w_rd_acc;
    assign rd_valid         = r_vld_p1;
    assign full             = w_full;
    assign empty            = w_empty;
    assign almost_full      = r_afull;
    assign almost_empty     = r_aempty;
    assign count            = r_count;

endmodule
